// File: rtl/knn_list_reader.sv
// knn_list_reader: drains the sorted KNN neighbour list as (distance, label,
// index) entries over a valid/ready handshake, nearest first.
// A start pulse snapshots the packed list. The block then emits
// min(k, N_elem) entries and pulses done.
// Optional feature: define KNN_READER_SKIP_EMPTY_EN to end the stream at the
// first entry whose distance is the all-ones empty-slot sentinel.
module knn_list_reader #(
  parameter int DATA_W = 32,
  parameter int N_elem = 10
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [DATA_W-1:0]            k,
  input  logic [2*N_elem*DATA_W-1:0]   mem,
  output logic                         busy,
  output logic                         done,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_W-1:0]            out_dist,
  output logic [DATA_W-1:0]            out_label,
  output logic [DATA_W-1:0]            out_index
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_STREAM = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  localparam logic [DATA_W-1:0] N_VAL = DATA_W'(N_elem);
  localparam logic [DATA_W-1:0] EMPTY = '1;

  logic [1:0]                   r_state;
  logic [2*N_elem*DATA_W-1:0]   r_snap;
  logic [DATA_W-1:0]            r_k_eff;
  logic [DATA_W-1:0]            r_idx;
  logic                         r_out_valid;
  logic [DATA_W-1:0]            r_out_dist;
  logic [DATA_W-1:0]            r_out_label;
  logic [DATA_W-1:0]            r_out_index;

  logic [DATA_W-1:0]            w_k_eff;
  logic [DATA_W-1:0]            w_first_dist;
  logic [DATA_W-1:0]            w_first_label;
  logic [DATA_W-1:0]            w_next_idx;
  logic [DATA_W-1:0]            w_next_dist;
  logic [DATA_W-1:0]            w_next_label;
  logic                         w_last;
  logic                         w_first_empty;
  logic                         w_next_empty;

  // Entry count clamped to the list length (unsigned compare).
  assign w_k_eff       = (k > N_VAL) ? N_VAL : k;
  assign w_first_dist  = mem[DATA_W-1:0];
  assign w_first_label = mem[2*DATA_W-1:DATA_W];
  assign w_next_idx    = r_idx + 1'b1;
  assign w_last        = (r_idx == r_k_eff - 1'b1);

  // Select the snapshot entry following the one currently presented.
  // NOTE: every always_comb output gets a default first so no latch is inferred
  // when no entry index matches (next index past the end of the list).
  always_comb begin
    w_next_dist  = '0;
    w_next_label = '0;
    for (int i = 0; i < N_elem; i++) begin
      if (w_next_idx == DATA_W'(i)) begin
        w_next_dist  = r_snap[2*i*DATA_W +: DATA_W];
        w_next_label = r_snap[(2*i+1)*DATA_W +: DATA_W];
      end
    end
  end

`ifdef KNN_READER_SKIP_EMPTY_EN
  assign w_first_empty = (w_first_dist == EMPTY);
  assign w_next_empty  = (w_next_dist == EMPTY);
`else
  assign w_first_empty = 1'b0;
  assign w_next_empty  = 1'b0;
`endif

  // Control FSM, snapshot capture and registered output entry.
  // NOTE: sequential state uses non-blocking assignments only. The snapshot is
  // cleared on reset like the other state, so no stale list survives an abort.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_snap      <= '0;
      r_k_eff     <= '0;
      r_idx       <= '0;
      r_out_valid <= 1'b0;
      r_out_dist  <= '0;
      r_out_label <= '0;
      r_out_index <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_snap  <= mem;
            r_k_eff <= w_k_eff;
            r_idx   <= '0;
            if ((w_k_eff == '0) || w_first_empty) begin
              r_state <= S_DONE;
            end else begin
              r_state     <= S_STREAM;
              r_out_valid <= 1'b1;
              r_out_dist  <= w_first_dist;
              r_out_label <= w_first_label;
              r_out_index <= '0;
            end
          end
        end
        S_STREAM: begin
          if (r_out_valid && out_ready) begin
            if (w_last || w_next_empty) begin
              r_out_valid <= 1'b0;
              r_state     <= S_DONE;
            end else begin
              r_idx       <= w_next_idx;
              r_out_dist  <= w_next_dist;
              r_out_label <= w_next_label;
              r_out_index <= w_next_idx;
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy      = (r_state == S_STREAM);
  assign done      = (r_state == S_DONE);
  assign out_valid = r_out_valid;
  assign out_dist  = r_out_dist;
  assign out_label = r_out_label;
  assign out_index = r_out_index;

endmodule
